branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
// - EXEC-side consumer of FETCH-stage branch predictions.
// - Carries each fetched instruction's prediction (pc, valid, predicted target) through DECODE to EXEC.
// - Compares the prediction against the actual branch outcome.
// - Issues a one-cycle redirect and squash on mispredict, plus the training update the predictor consumes.
// - Sits between the core's EXEC stage and the predictor/fetch PC mux; keeps saturating statistics.
// PARAMETERS
// - XLEN   32  address width
// - CNT_W  16  width of the statistics counters
// PORTS
// - clk              in   1      single clock, rising edge
// - rst_n            in   1      asynchronous, active-low reset
// - f_valid          in   1      FETCH instruction valid this cycle
// - f_pc             in   XLEN   FETCH PC
// - f_predict_valid  in   1      predictor hit for f_pc
// - f_predict_addr   in   XLEN   predicted target for f_pc
// - stall            in   1      pipeline hold; all stage registers keep their value
// - x_is_branch      in   1      EXEC instruction is a conditional branch
// - x_taken          in   1      EXEC branch actually taken
// - x_target         in   XLEN   EXEC computed branch target
// - redirect_valid   out  1      mispredict; fetch must load redirect_pc
// - redirect_pc      out  XLEN   correct next PC
// - upd_valid        out  1      predictor training pulse
// - upd_pc           out  XLEN   branch PC to train
// - upd_taken        out  1      actual outcome
// - upd_target       out  XLEN   actual target (x_target)
// - upd_alloc        out  1      branch was not predicted; allocate a new entry
// - stat_branches    out  CNT_W  resolved branches, saturating
// - stat_mispredicts out  CNT_W  redirects issued, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - All outputs 0.
//   - d_meta.valid and x_meta.valid cleared.
//   - Counters 0.
//   - Takes effect mid-operation with no residual pulses.
// - Stage registers:
//   - d_meta captures {f_valid, f_pc, f_predict_valid, f_predict_addr}.
//   - x_meta captures d_meta.
//   - Both advance only when stall=0.
// - Resolution occurs on an edge where x_meta.valid=1 and stall=0.
//   - Outcome is registered; outputs pulse for exactly 1 cycle after that edge (latency 1).
// - Outcome table (pv = x_meta.pred_valid, pa = x_meta.pred_addr, pc = x_meta.pc; pc+4 wraps mod 2^XLEN):
//   - branch, pv, taken, x_target==pa   -> correct; upd_valid=1, upd_taken=1
//   - branch, pv, taken, x_target!=pa   -> redirect to x_target; upd_valid=1, upd_taken=1
//   - branch, pv, not taken             -> redirect to pc+4; upd_valid=1, upd_taken=0
//   - branch, !pv, taken                -> redirect to x_target; upd_valid=1, upd_alloc=1
//   - branch, !pv, not taken            -> correct; no update
//   - non-branch, pv                    -> redirect to pc+4; no update (stale entry)
//   - non-branch, !pv                   -> nothing
// - Update fields:
//   - upd_pc = pc; upd_target = x_target.
//   - upd_alloc is 0 whenever upd_valid=0.
// - Squash:
//   - On the resolution edge that raises redirect_valid, x_meta and d_meta load invalid (younger wrong-path work).
//   - During the redirect_valid cycle, f_valid is ignored; d_meta loads invalid at that edge even if stall=1.
//   - Squash overrides stall.
// - Back-to-back: a correct resolution does not block the next; the next cycle may resolve again.
// - Statistics:
//   - stat_branches increments on every resolved branch.
//   - stat_mispredicts increments on every redirect.
//   - Both hold at 2^CNT_W-1.
// - Stall while x_meta.valid: no resolution and no pulses; outputs return to 0 after any pulse.
// TESTING
// - pc=0x100, pred 0x200; EXEC taken, target 0x200 -> no redirect; upd_valid=1, upd_taken=1, upd_alloc=0; branches=1, mispredicts=0.
// - pc=0x100, pred 0x200; EXEC not taken -> redirect_pc=0x104; upd_taken=0; mispredicts=1.
// - pc=0x300, no prediction; taken, target 0x340 -> redirect_pc=0x340; upd_alloc=1, upd_target=0x340.
// - pc=0x400, pred 0x480, non-branch -> redirect_pc=0x404; upd_valid=0; branches unchanged.
// - Mispredict at 0x100 with two younger fetches 0x104/0x108 queued and f_valid=1 during the redirect cycle -> no further pulses until new valid fetches reach EXEC.
// - Stall=1 for 3 cycles with a branch in EXEC -> no pulse until release.
// - rst_n low mid-flight -> all outputs/counters 0 immediately; no pulse after release.
// - Counters forced near max with CNT_W=4 -> hold at 15.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: carries fetch-time predictions down to EXEC, checks them against the
// real branch outcome, and emits a one-cycle redirect/squash plus a predictor training update.
// Also keeps saturating branch and mispredict counters.
module branch_resolver #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [XLEN-1:0]  f_pc,
    input  logic             f_predict_valid,
    input  logic [XLEN-1:0]  f_predict_addr,
    input  logic             stall,
    input  logic             x_is_branch,
    input  logic             x_taken,
    input  logic [XLEN-1:0]  x_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [XLEN-1:0]  upd_target,
    output logic             upd_alloc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_valid;
        logic [XLEN-1:0] pred_addr;
    } meta_t;

    localparam logic [CNT_W-1:0] CntMax = '1;

    meta_t d_meta_q, d_meta_d;
    meta_t x_meta_q, x_meta_d;

    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             upd_valid_q, upd_valid_d;
    logic [XLEN-1:0]  upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic [XLEN-1:0]  upd_target_q, upd_target_d;
    logic             upd_alloc_q, upd_alloc_d;
    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

    logic            resolve;
    logic            mispredict;
    logic            need_upd;
    logic            alloc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redir_tgt;
    logic            fire_redirect;
    logic            fire_upd;

    // Classify the instruction in EXEC against its carried prediction.
    always_comb begin
        resolve    = x_meta_q.valid && !stall;
        pc_plus4   = x_meta_q.pc + XLEN'(4);
        mispredict = 1'b0;
        need_upd   = 1'b0;
        alloc      = 1'b0;
        redir_tgt  = pc_plus4;
        if (x_is_branch) begin
            if (x_meta_q.pred_valid) begin
                need_upd = 1'b1;
                if (x_taken) begin
                    redir_tgt  = x_target;
                    mispredict = (x_target != x_meta_q.pred_addr);
                end else begin
                    mispredict = 1'b1;
                end
            end else if (x_taken) begin
                need_upd   = 1'b1;
                alloc      = 1'b1;
                mispredict = 1'b1;
                redir_tgt  = x_target;
            end
        end else if (x_meta_q.pred_valid) begin
            // Predictor hit on a non-branch: stale entry, fall through to pc+4.
            mispredict = 1'b1;
        end
        fire_redirect = resolve && mispredict;
        fire_upd      = resolve && need_upd;
    end

    // Next-state for pulse outputs, stage registers and statistics.
    always_comb begin
        redirect_valid_d = fire_redirect;
        redirect_pc_d    = fire_redirect ? redir_tgt : '0;
        upd_valid_d      = fire_upd;
        upd_pc_d         = fire_upd ? x_meta_q.pc : '0;
        upd_taken_d      = fire_upd && x_taken;
        upd_target_d     = fire_upd ? x_target : '0;
        upd_alloc_d      = fire_upd && alloc;

        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (resolve && x_is_branch && (branches_q != CntMax)) begin
            branches_d = branches_q + CNT_W'(1);
        end
        if (fire_redirect && (mispredicts_q != CntMax)) begin
            mispredicts_d = mispredicts_q + CNT_W'(1);
        end

        d_meta_d = d_meta_q;
        if (!stall) begin
            d_meta_d = '{valid: f_valid, pc: f_pc, pred_valid: f_predict_valid,
                         pred_addr: f_predict_addr};
        end
        // Squash overrides stall; the fetch seen during the redirect cycle is wrong-path.
        if (fire_redirect || redirect_valid_q) begin
            d_meta_d.valid = 1'b0;
        end

        x_meta_d = x_meta_q;
        if (!stall) begin
            x_meta_d = d_meta_q;
        end
        if (fire_redirect) begin
            x_meta_d.valid = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_meta_q         <= '0;
            x_meta_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= '0;
            upd_alloc_q      <= 1'b0;
            branches_q       <= '0;
            mispredicts_q    <= '0;
        end else begin
            d_meta_q         <= d_meta_d;
            x_meta_q         <= x_meta_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            upd_target_q     <= upd_target_d;
            upd_alloc_q      <= upd_alloc_d;
            branches_q       <= branches_d;
            mispredicts_q    <= mispredicts_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_taken        = upd_taken_q;
    assign upd_target       = upd_target_q;
    assign upd_alloc        = upd_alloc_q;
    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with 4-bit statistics counters.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_predict_valid;
    logic [31:0] f_predict_addr;
    logic        stall;
    logic        x_is_branch;
    logic        x_taken;
    logic [31:0] x_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_alloc;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolver #(.XLEN(32), .CNT_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_valid          (f_valid),
        .f_pc             (f_pc),
        .f_predict_valid  (f_predict_valid),
        .f_predict_addr   (f_predict_addr),
        .stall            (stall),
        .x_is_branch      (x_is_branch),
        .x_taken          (x_taken),
        .x_target         (x_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_alloc        (upd_alloc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Idle one cycle, then push one instruction to EXEC and resolve it.
    task automatic run_one(input logic [31:0] pc, input logic pv, input logic [31:0] pa,
                           input logic br, input logic tk, input logic [31:0] tgt);
        stall = 0; f_valid = 0; x_is_branch = 0; x_taken = 0;
        cycle();
        check("idle_redirect", 32'(redirect_valid), 0);
        f_valid = 1; f_pc = pc; f_predict_valid = pv; f_predict_addr = pa;
        cycle();
        f_valid = 0;
        cycle();
        x_is_branch = br; x_taken = tk; x_target = tgt;
        cycle();
        x_is_branch = 0; x_taken = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_redir"}, 32'(redirect_valid), 0);
        check({tag, "_upd"}, 32'(upd_valid), 0);
    endtask

    initial begin
        rst_n = 0; f_valid = 0; f_pc = 0; f_predict_valid = 0; f_predict_addr = 0;
        stall = 0; x_is_branch = 0; x_taken = 0; x_target = 0;
        #12;
        check("rst_redirect", 32'(redirect_valid), 0);
        check("rst_upd", 32'(upd_valid), 0);
        check("rst_branches", 32'(stat_branches), 0);
        check("rst_mispred", 32'(stat_mispredicts), 0);
        rst_n = 1;

        // Correct taken prediction.
        run_one(32'h100, 1, 32'h200, 1, 1, 32'h200);
        check("t1_redirect", 32'(redirect_valid), 0);
        check("t1_upd_valid", 32'(upd_valid), 1);
        check("t1_upd_taken", 32'(upd_taken), 1);
        check("t1_upd_alloc", 32'(upd_alloc), 0);
        check("t1_upd_pc", upd_pc, 32'h100);
        check("t1_branches", 32'(stat_branches), 1);
        check("t1_mispred", 32'(stat_mispredicts), 0);

        // Predicted, not taken.
        run_one(32'h100, 1, 32'h200, 1, 0, 32'h200);
        check("t2_redirect", 32'(redirect_valid), 1);
        check("t2_redirect_pc", redirect_pc, 32'h104);
        check("t2_upd_valid", 32'(upd_valid), 1);
        check("t2_upd_taken", 32'(upd_taken), 0);
        check("t2_mispred", 32'(stat_mispredicts), 1);

        // Unpredicted taken: allocate.
        run_one(32'h300, 0, 32'h0, 1, 1, 32'h340);
        check("t3_redirect_pc", redirect_pc, 32'h340);
        check("t3_upd_alloc", 32'(upd_alloc), 1);
        check("t3_upd_target", upd_target, 32'h340);
        check("t3_upd_taken", 32'(upd_taken), 1);
        check("t3_branches", 32'(stat_branches), 3);

        // Stale predictor entry on non-branch.
        run_one(32'h400, 1, 32'h480, 0, 0, 32'h0);
        check("t4_redirect", 32'(redirect_valid), 1);
        check("t4_redirect_pc", redirect_pc, 32'h404);
        check("t4_upd_valid", 32'(upd_valid), 0);
        check("t4_branches", 32'(stat_branches), 3);
        check("t4_mispred", 32'(stat_mispredicts), 3);

        // Unpredicted not taken: nothing but the branch count.
        run_one(32'h420, 0, 32'h0, 1, 0, 32'h500);
        check_quiet("t4b");
        check("t4b_branches", 32'(stat_branches), 4);

        // Predicted taken, wrong target.
        run_one(32'h440, 1, 32'h600, 1, 1, 32'h680);
        check("t4c_redirect_pc", redirect_pc, 32'h680);
        check("t4c_upd_taken", 32'(upd_taken), 1);
        check("t4c_upd_alloc", 32'(upd_alloc), 0);
        check("t4c_mispred", 32'(stat_mispredicts), 4);

        // Squash of younger work, fetch ignored during redirect cycle.
        stall = 0; f_valid = 0; x_is_branch = 0;
        cycle();
        f_valid = 1; f_pc = 32'h100; f_predict_valid = 1; f_predict_addr = 32'h200;
        cycle();
        f_pc = 32'h104; f_predict_valid = 0;
        cycle();
        f_pc = 32'h108; x_is_branch = 1; x_taken = 0;
        cycle();
        check("t5_redirect", 32'(redirect_valid), 1);
        check("t5_redirect_pc", redirect_pc, 32'h104);
        f_pc = 32'h10c; x_is_branch = 1; x_taken = 1; x_target = 32'h999;
        cycle();
        check_quiet("t5_sq0");
        f_valid = 0;
        cycle();
        check_quiet("t5_sq1");
        cycle();
        check_quiet("t5_sq2");
        check("t5_branches", 32'(stat_branches), 6);
        f_valid = 1; f_pc = 32'h500;
        cycle();
        f_valid = 0;
        cycle();
        cycle();
        check("t5_new_alloc", 32'(upd_alloc), 1);
        check("t5_new_pc", upd_pc, 32'h500);
        check("t5_new_redirect_pc", redirect_pc, 32'h999);
        x_is_branch = 0; x_taken = 0;

        // Stall holds the branch in EXEC.
        cycle();
        f_valid = 1; f_pc = 32'h600; f_predict_valid = 1; f_predict_addr = 32'h640;
        cycle();
        f_valid = 0;
        cycle();
        stall = 1; x_is_branch = 1; x_taken = 1; x_target = 32'h640;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_quiet("t6_stall");
        end
        stall = 0;
        cycle();
        check("t6_release_upd", 32'(upd_valid), 1);
        check("t6_release_pc", upd_pc, 32'h600);
        check("t6_release_redir", 32'(redirect_valid), 0);
        x_is_branch = 0; x_taken = 0;
        cycle();
        check_quiet("t6_after");

        // Back-to-back correct resolutions.
        f_valid = 1; f_predict_valid = 1; f_predict_addr = 32'h900; f_pc = 32'h800;
        cycle();
        f_pc = 32'h804;
        cycle();
        f_pc = 32'h808; x_is_branch = 1; x_taken = 1; x_target = 32'h900;
        cycle();
        check("t7_b0_pc", upd_pc, 32'h800);
        f_valid = 0;
        cycle();
        check("t7_b1_pc", upd_pc, 32'h804);
        check("t7_b1_upd", 32'(upd_valid), 1);
        cycle();
        check("t7_b2_pc", upd_pc, 32'h808);
        check("t7_branches", 32'(stat_branches), 11);
        x_is_branch = 0; x_taken = 0;
        cycle();
        check_quiet("t7_after");

        // Asynchronous reset mid-flight.
        f_valid = 1; f_pc = 32'h700; f_predict_valid = 1; f_predict_addr = 32'h780;
        cycle();
        f_pc = 32'h704;
        cycle();
        f_valid = 0; x_is_branch = 1; x_taken = 1; x_target = 32'h780;
        cycle();
        check("t8_pre_upd", 32'(upd_valid), 1);
        #2;
        rst_n = 0;
        #1;
        check("t8_rst_upd", 32'(upd_valid), 0);
        check("t8_rst_pc", upd_pc, 0);
        check("t8_rst_branches", 32'(stat_branches), 0);
        x_taken = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_quiet("t8_post");
        end
        check("t8_post_branches", 32'(stat_branches), 0);

        // Saturation at 15 with 4-bit counters.
        for (int i = 0; i < 17; i++) begin
            run_one(32'h1000 + 32'(i) * 32'h10, 0, 32'h0, 1, 1, 32'h2000);
            if (i == 13) check("t9_branches_14", 32'(stat_branches), 14);
            if (i == 14) check("t9_mispred_15", 32'(stat_mispredicts), 15);
        end
        check("t9_branches_sat", 32'(stat_branches), 15);
        check("t9_mispred_sat", 32'(stat_mispredicts), 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
